multicycle_control: RTL and testbench

- Multi-cycle successor to the single-cycle combinational Control decoder in the basic processor.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states and drives the same datapath control set per state.
- Adds a data-memory ready handshake with timeout, a halt/restart mechanism, illegal-opcode flagging and a retired-instruction counter.
- Sits between the instruction register/data memory and the datapath muxes, register file and ALU.

---
 rtl/multicycle_control_pkg.sv | 57 +++++
 rtl/multicycle_control_mem_wait_timer.sv | 44 ++++
 rtl/multicycle_control.sv | 192 +++++++++++++++++++
 tb/tb_multicycle_control.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/multicycle_control_pkg.sv
// ============================================================================
// Module      : multicycle_control_pkg
// Description : Shared types and encodings for the multi-cycle control unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package multicycle_control_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALTED = 3'd6
  } state_t;

  localparam logic [3:0] OP_RTYPE = 4'd0;
  localparam logic [3:0] OP_LW    = 4'd1;
  localparam logic [3:0] OP_SW    = 4'd2;
  localparam logic [3:0] OP_BEQ   = 4'd3;
  localparam logic [3:0] OP_ADDI  = 4'd4;
  localparam logic [3:0] OP_HALT  = 4'd15;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG = 2'b00;
  localparam logic [1:0] SRCB_ONE = 2'b01;
  localparam logic [1:0] SRCB_IMM = 2'b10;

  typedef struct packed {
    logic [1:0] alu_op;
    logic [1:0] alu_src_b;
    logic       reg_write;
    logic       branch;
    logic       mem_write;
    logic       mem_read;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       ir_write;
    logic       pc_write;
    logic       halt;
    logic       illegal;
  } ctrl_t;

  function automatic logic op_lo_legal(input logic [3:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_HALT);
  endfunction

endpackage

`default_nettype wire

// File: rtl/multicycle_control_mem_wait_timer.sv
// ============================================================================
// Module      : multicycle_control_mem_wait_timer
// Description : Counts MEM cycles spent waiting for ready; flags timeout.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_control_mem_wait_timer #(
  parameter int unsigned LIMIT = 15
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  generate
    if (LIMIT == 0) begin : g_disabled
      assign expired = 1'b0;
    end else begin : g_enabled
      localparam int W = (LIMIT < 2) ? 1 : $clog2(LIMIT);
      localparam logic [W-1:0] c_last = W'(LIMIT - 1);

      logic [W-1:0] r_cnt;

      // Expiry fires on the edge that would make the count reach LIMIT.
      assign expired = enable && (r_cnt == c_last);

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_cnt <= '0;
        end else if (clear) begin
          r_cnt <= '0;
        end else if (enable && (r_cnt != c_last)) begin
          r_cnt <= r_cnt + W'(1);
        end
      end
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/multicycle_control.sv
// ============================================================================
// Module      : multicycle_control
// Description : Multi-cycle instruction sequencer driving datapath controls.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int unsigned OPCODE_W    = 4,
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  output logic [1:0]          alu_op,
  output logic [1:0]          alu_src_b,
  output logic                reg_write,
  output logic                branch,
  output logic                mem_write,
  output logic                mem_read,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                ir_write,
  output logic                pc_write,
  output logic                halt,
  output logic                illegal,
  output logic                error,
  output logic [CNT_W-1:0]    instr_count
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [OPCODE_W-1:0] r_op_q;
  logic [OPCODE_W-1:0] w_op_nxt;
  ctrl_t               r_ctrl;
  logic                r_error;
  logic [CNT_W-1:0]    r_count;
  logic                w_done;
  logic                w_timeout;
  logic                w_expired;

  function automatic logic op_legal(input logic [OPCODE_W-1:0] op);
    return ((op >> 4) == '0) && op_lo_legal(op[3:0]);
  endfunction

  // Control word for a given state and latched opcode.
  function automatic ctrl_t decode(input state_t s, input logic [OPCODE_W-1:0] op);
    ctrl_t c;
    c = '0;
    case (s)
      ST_FETCH: begin
        c.ir_write  = 1'b1;
        c.pc_write  = 1'b1;
        c.alu_op    = ALU_ADD;
        c.alu_src_b = SRCB_ONE;
        c.illegal   = !op_legal(op);
      end
      ST_EXEC: begin
        case (op[3:0])
          OP_RTYPE: begin
            c.alu_op    = ALU_FUNCT;
            c.alu_src_b = SRCB_REG;
          end
          OP_LW, OP_SW, OP_ADDI: begin
            c.alu_op    = ALU_ADD;
            c.alu_src_b = SRCB_IMM;
          end
          OP_BEQ: begin
            c.alu_op    = ALU_SUB;
            c.alu_src_b = SRCB_REG;
            c.branch    = 1'b1;
          end
          default: c = '0;
        endcase
      end
      ST_MEM: begin
        c.mem_read  = (op[3:0] == OP_LW);
        c.mem_write = (op[3:0] == OP_SW);
      end
      ST_WB: begin
        c.reg_write  = 1'b1;
        c.reg_dst    = (op[3:0] == OP_RTYPE);
        c.mem_to_reg = (op[3:0] == OP_LW);
      end
      ST_HALTED: c.halt = 1'b1;
      default:   c = '0;
    endcase
    return c;
  endfunction

  multicycle_control_mem_wait_timer #(
    .LIMIT (MEM_TIMEOUT)
  ) u_mem_wait_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (r_state != ST_MEM),
    .enable  ((r_state == ST_MEM) && !mem_ready),
    .expired (w_expired)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_op_nxt    = r_op_q;
    w_done      = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      ST_IDLE: if (start) w_state_nxt = ST_FETCH;
      ST_FETCH: w_state_nxt = ST_DECODE;
      ST_DECODE: begin
        w_op_nxt = opcode;
        if (!op_legal(opcode)) begin
          w_state_nxt = ST_FETCH;
        end else if (opcode[3:0] == OP_HALT) begin
          w_state_nxt = ST_HALTED;
          w_done      = 1'b1;
        end else begin
          w_state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        case (r_op_q[3:0])
          OP_RTYPE, OP_ADDI: w_state_nxt = ST_WB;
          OP_LW, OP_SW:      w_state_nxt = ST_MEM;
          OP_BEQ: begin
            w_state_nxt = ST_FETCH;
            w_done      = 1'b1;
          end
          default: w_state_nxt = ST_FETCH;
        endcase
      end
      ST_MEM: begin
        // A ready on the same edge as expiry completes the access.
        if (mem_ready) begin
          if (r_op_q[3:0] == OP_LW) begin
            w_state_nxt = ST_WB;
          end else begin
            w_state_nxt = ST_FETCH;
            w_done      = 1'b1;
          end
        end else if (w_expired) begin
          w_state_nxt = ST_HALTED;
          w_timeout   = 1'b1;
        end
      end
      ST_WB: begin
        w_state_nxt = ST_FETCH;
        w_done      = 1'b1;
      end
      ST_HALTED: if (start) w_state_nxt = ST_FETCH;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_op_q  <= '0;
      r_ctrl  <= '0;
      r_error <= 1'b0;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_op_q  <= w_op_nxt;
      r_ctrl  <= decode(w_state_nxt, w_op_nxt);
      if (w_timeout) r_error <= 1'b1;
      if (w_done)    r_count <= r_count + CNT_W'(1);
    end
  end

  assign alu_op      = r_ctrl.alu_op;
  assign alu_src_b   = r_ctrl.alu_src_b;
  assign reg_write   = r_ctrl.reg_write;
  assign branch      = r_ctrl.branch;
  assign mem_write   = r_ctrl.mem_write;
  assign mem_read    = r_ctrl.mem_read;
  assign reg_dst     = r_ctrl.reg_dst;
  assign mem_to_reg  = r_ctrl.mem_to_reg;
  assign ir_write    = r_ctrl.ir_write;
  assign pc_write    = r_ctrl.pc_write;
  assign halt        = r_ctrl.halt;
  assign illegal     = r_ctrl.illegal;
  assign error       = r_error;
  assign instr_count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control.sv
// ============================================================================
// Module      : tb_multicycle_control
// Description : Directed, table-driven self-checking bench for multicycle_control.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_control;

  // Control word order: alu_op, alu_src_b, reg_write, branch, mem_write,
  // mem_read, reg_dst, mem_to_reg, ir_write, pc_write, halt, illegal
  localparam logic [13:0] C_ZERO      = 14'b00_00_0_0_0_0_0_0_0_0_0_0;
  localparam logic [13:0] C_FETCH     = 14'b00_01_0_0_0_0_0_0_1_1_0_0;
  localparam logic [13:0] C_FETCH_ILL = 14'b00_01_0_0_0_0_0_0_1_1_0_1;
  localparam logic [13:0] C_EX_R      = 14'b10_00_0_0_0_0_0_0_0_0_0_0;
  localparam logic [13:0] C_EX_I      = 14'b00_10_0_0_0_0_0_0_0_0_0_0;
  localparam logic [13:0] C_EX_BEQ    = 14'b01_00_0_1_0_0_0_0_0_0_0_0;
  localparam logic [13:0] C_MEM_RD    = 14'b00_00_0_0_0_1_0_0_0_0_0_0;
  localparam logic [13:0] C_MEM_WR    = 14'b00_00_0_0_1_0_0_0_0_0_0_0;
  localparam logic [13:0] C_WB_R      = 14'b00_00_1_0_0_0_1_0_0_0_0_0;
  localparam logic [13:0] C_WB_LW     = 14'b00_00_1_0_0_0_0_1_0_0_0_0;
  localparam logic [13:0] C_WB_I      = 14'b00_00_1_0_0_0_0_0_0_0_0_0;
  localparam logic [13:0] C_HALT      = 14'b00_00_0_0_0_0_0_0_0_0_1_0;

  typedef struct {
    logic        start;
    logic [3:0]  opcode;
    logic        ready;
    logic [13:0] exp_ctrl;
    logic        exp_err;
    logic [15:0] exp_cnt;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [3:0]  opcode;
  logic        mem_ready;
  logic [1:0]  alu_op;
  logic [1:0]  alu_src_b;
  logic        reg_write, branch, mem_write, mem_read, reg_dst, mem_to_reg;
  logic        ir_write, pc_write, halt, illegal, error;
  logic [15:0] instr_count;
  logic [13:0] got_ctrl;

  int n_vec = 0;
  int n_bad = 0;
  vec_t vecs[$];

  assign got_ctrl = {alu_op, alu_src_b, reg_write, branch, mem_write, mem_read,
                     reg_dst, mem_to_reg, ir_write, pc_write, halt, illegal};

  always #5 clk = ~clk;

  multicycle_control #(
    .OPCODE_W    (4),
    .MEM_TIMEOUT (15),
    .CNT_W       (16)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .opcode      (opcode),
    .mem_ready   (mem_ready),
    .alu_op      (alu_op),
    .alu_src_b   (alu_src_b),
    .reg_write   (reg_write),
    .branch      (branch),
    .mem_write   (mem_write),
    .mem_read    (mem_read),
    .reg_dst     (reg_dst),
    .mem_to_reg  (mem_to_reg),
    .ir_write    (ir_write),
    .pc_write    (pc_write),
    .halt        (halt),
    .illegal     (illegal),
    .error       (error),
    .instr_count (instr_count)
  );

  task automatic add(input logic s, input logic [3:0] op, input logic rdy,
                     input logic [13:0] ec, input logic ee, input logic [15:0] cnt);
    vec_t v;
    v.start = s; v.opcode = op; v.ready = rdy;
    v.exp_ctrl = ec; v.exp_err = ee; v.exp_cnt = cnt;
    vecs.push_back(v);
  endtask

  // Drive inputs, clock once, sample 1 ns after the edge.
  task automatic cycle(input logic s, input logic [3:0] op, input logic rdy);
    start = s; opcode = op; mem_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int idx, input logic [13:0] ec,
                       input logic ee, input logic [15:0] cnt);
    n_vec++;
    if (got_ctrl !== ec || error !== ee || instr_count !== cnt) begin
      n_bad++;
      $display("FAIL %s[%0d]: got ctrl=%b err=%b cnt=%0d, want ctrl=%b err=%b cnt=%0d",
               tag, idx, got_ctrl, error, instr_count, ec, ee, cnt);
    end
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; opcode = 4'd0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset", 0, C_ZERO, 1'b0, 16'd0);
    @(negedge clk);
    reset_n = 1'b1;

    add(0, 4'd0, 0, C_ZERO,      0, 16'd0);   // IDLE holds without start
    // RTYPE
    add(1, 4'd0, 0, C_FETCH,     0, 16'd0);
    add(0, 4'd0, 0, C_ZERO,      0, 16'd0);
    add(0, 4'd0, 0, C_EX_R,      0, 16'd0);
    add(0, 4'd0, 0, C_WB_R,      0, 16'd0);
    add(0, 4'd0, 0, C_FETCH,     0, 16'd1);
    // LW, three wait cycles
    add(0, 4'd1, 0, C_ZERO,      0, 16'd1);
    add(0, 4'd1, 0, C_EX_I,      0, 16'd1);
    add(0, 4'd1, 0, C_MEM_RD,    0, 16'd1);
    add(0, 4'd1, 0, C_MEM_RD,    0, 16'd1);
    add(0, 4'd1, 0, C_MEM_RD,    0, 16'd1);
    add(0, 4'd1, 0, C_MEM_RD,    0, 16'd1);
    add(0, 4'd1, 1, C_WB_LW,     0, 16'd1);
    add(0, 4'd1, 0, C_FETCH,     0, 16'd2);
    // BEQ
    add(0, 4'd3, 0, C_ZERO,      0, 16'd2);
    add(0, 4'd3, 0, C_EX_BEQ,    0, 16'd2);
    add(0, 4'd3, 0, C_FETCH,     0, 16'd3);
    // illegal opcode
    add(0, 4'd7, 0, C_ZERO,      0, 16'd3);
    add(0, 4'd7, 0, C_FETCH_ILL, 0, 16'd3);
    // ADDI (start ignored outside IDLE/HALTED)
    add(1, 4'd4, 0, C_ZERO,      0, 16'd3);
    add(1, 4'd4, 0, C_EX_I,      0, 16'd3);
    add(0, 4'd4, 0, C_WB_I,      0, 16'd3);
    add(0, 4'd4, 0, C_FETCH,     0, 16'd4);
    // SW, one wait cycle
    add(0, 4'd2, 0, C_ZERO,      0, 16'd4);
    add(0, 4'd2, 0, C_EX_I,      0, 16'd4);
    add(0, 4'd2, 0, C_MEM_WR,    0, 16'd4);
    add(0, 4'd2, 0, C_MEM_WR,    0, 16'd4);
    add(0, 4'd2, 1, C_FETCH,     0, 16'd5);

    for (int i = 0; i < vecs.size(); i++) begin
      cycle(vecs[i].start, vecs[i].opcode, vecs[i].ready);
      check("table", i, vecs[i].exp_ctrl, vecs[i].exp_err, vecs[i].exp_cnt);
    end

    // SW with ready arriving on the very edge that would time out
    cycle(0, 4'd2, 0); check("rdywin_dec", 0, C_ZERO, 1'b0, 16'd5);
    cycle(0, 4'd2, 0); check("rdywin_ex", 0, C_EX_I, 1'b0, 16'd5);
    cycle(0, 4'd2, 0); check("rdywin_mem", 1, C_MEM_WR, 1'b0, 16'd5);
    for (int k = 2; k <= 15; k++) begin
      cycle(0, 4'd2, 0); check("rdywin_mem", k, C_MEM_WR, 1'b0, 16'd5);
    end
    cycle(0, 4'd2, 1); check("rdywin_exit", 0, C_FETCH, 1'b0, 16'd6);

    // SW that never gets ready: 15 MEM cycles then HALTED with ERROR
    cycle(0, 4'd2, 0); check("tmo_dec", 0, C_ZERO, 1'b0, 16'd6);
    cycle(0, 4'd2, 0); check("tmo_ex", 0, C_EX_I, 1'b0, 16'd6);
    cycle(0, 4'd2, 0); check("tmo_mem", 1, C_MEM_WR, 1'b0, 16'd6);
    for (int k = 2; k <= 15; k++) begin
      cycle(0, 4'd2, 0); check("tmo_mem", k, C_MEM_WR, 1'b0, 16'd6);
    end
    cycle(0, 4'd2, 0); check("tmo_halted", 0, C_HALT, 1'b1, 16'd6);
    cycle(0, 4'd2, 0); check("tmo_hold", 0, C_HALT, 1'b1, 16'd6);
    cycle(1, 4'd2, 0); check("tmo_restart", 0, C_FETCH, 1'b1, 16'd6);

    // HALT instruction counts as completed
    cycle(0, 4'd15, 0); check("halt_dec", 0, C_ZERO, 1'b1, 16'd6);
    cycle(0, 4'd15, 0); check("halt_state", 0, C_HALT, 1'b1, 16'd7);
    cycle(1, 4'd0, 0);  check("halt_restart", 0, C_FETCH, 1'b1, 16'd7);
    cycle(0, 4'd0, 0);  check("rst_dec", 0, C_ZERO, 1'b1, 16'd7);
    cycle(0, 4'd0, 0);  check("rst_ex", 0, C_EX_R, 1'b1, 16'd7);

    // Asynchronous reset mid-EXEC
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst", 0, C_ZERO, 1'b0, 16'd0);
    @(posedge clk);
    #1;
    check("async_rst_hold", 0, C_ZERO, 1'b0, 16'd0);
    @(negedge clk);
    reset_n = 1'b1;
    cycle(1, 4'd0, 0); check("post_rst", 0, C_FETCH, 1'b0, 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
